// File: rtl/fibo_pkg.sv
// Shared types and constants for the Fibonacci controller and its datapath.
package fibo_pkg;

  localparam int REG_ADDR_W = 2;

  localparam logic [2:0] OP_PASS_A = 3'b001;
  localparam logic [2:0] OP_ADD    = 3'b110;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic [2:0] {
    IDLE,
    INIT0,
    INIT1,
    COMPUTE,
    DONE,
    ERR
  } state_t;

  typedef struct packed {
    logic      wrt_en;
    logic      load_data;
    reg_addr_t wrt_addr;
    reg_addr_t rd_addr1;
    reg_addr_t rd_addr2;
    logic [2:0] alu_opcode;
  } ctrl_t;

  // Datapath idles presenting register addr on the data bus.
  function automatic ctrl_t park(input reg_addr_t addr);
    ctrl_t c;
    c            = '0;
    c.rd_addr1   = addr;
    c.alu_opcode = OP_PASS_A;
    return c;
  endfunction

  function automatic ctrl_t load_reg(input reg_addr_t addr);
    ctrl_t c;
    c            = '0;
    c.wrt_en     = 1'b1;
    c.load_data  = 1'b1;
    c.wrt_addr   = addr;
    c.alu_opcode = OP_PASS_A;
    return c;
  endfunction

  // Rotating add: reg[k+2] = reg[k+1] + reg[k], addresses wrap mod 4.
  function automatic ctrl_t add_step(input reg_addr_t k);
    ctrl_t c;
    c            = '0;
    c.wrt_en     = 1'b1;
    c.rd_addr2   = k;
    c.rd_addr1   = k + 2'd1;
    c.wrt_addr   = k + 2'd2;
    c.alu_opcode = OP_ADD;
    return c;
  endfunction

endpackage

// File: rtl/fibo_if.sv
// Control/status bundle between the Fibonacci controller (master) and
// its datapath plus requester (slave).
interface fibo_if #(parameter int SIZE = 4);
  import fibo_pkg::*;

  logic            start;
  logic [SIZE-1:0] n;
  logic            zero_flag;
  logic [SIZE-1:0] data;
  logic            wrt_en;
  logic            load_data;
  reg_addr_t       wrt_addr;
  reg_addr_t       rd_addr1;
  reg_addr_t       rd_addr2;
  logic [2:0]      alu_opcode;
  logic [SIZE-1:0] count;
  logic            busy;
  logic            done;
  logic            err;

  modport master (
    input  start, n, zero_flag, data,
    output wrt_en, load_data, wrt_addr, rd_addr1, rd_addr2, alu_opcode,
           count, busy, done, err
  );

  modport slave (
    output start, n, zero_flag, data,
    input  wrt_en, load_data, wrt_addr, rd_addr1, rd_addr2, alu_opcode,
           count, busy, done, err
  );
endinterface

// File: rtl/fibo_controller.sv
// Control FSM sequencing the Fibonacci datapath to compute term F(n).
// Optional macro FIBO_OVF_DETECT_EN: flag unsigned wrap of an ADD as an error.
module fibo_controller
  import fibo_pkg::*;
#(
  parameter int SIZE = 4
) (
  input logic   clk,
  input logic   rst_n,
  fibo_if.master bus
);

  state_t          state;
  ctrl_t           ctrl;
  logic [SIZE-1:0] count_q;
  logic [SIZE-1:0] n_q;
  logic [SIZE-1:0] k;
  reg_addr_t       last_addr;
  logic            busy_q;
  logic            done_q;
  logic            err_q;
  logic            fault;

`ifdef FIBO_OVF_DETECT_EN
  logic [SIZE-1:0] prev_a;

  // Operand A of each add is the previous sum (or the constant 1 on the first add).
  always_ff @(posedge clk) begin
    if (!rst_n)                prev_a <= '0;
    else if (state == INIT1)   prev_a <= SIZE'(1);
    else if (state == COMPUTE) prev_a <= bus.data;
  end

  assign fault = bus.zero_flag || (bus.data < prev_a);
`else
  logic unused_data;
  assign unused_data = ^bus.data;
  assign fault       = bus.zero_flag;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ctrl      <= park('0);
      count_q   <= '0;
      n_q       <= '0;
      k         <= '0;
      last_addr <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: outputs are loaded for the destination state, so each branch
      // sets the controls the datapath must see during the next cycle.
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            n_q     <= bus.n;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            count_q <= SIZE'(1);
            ctrl    <= load_reg(2'd0);
            state   <= INIT0;
          end
        end
        INIT0: begin
          count_q <= SIZE'(1);
          ctrl    <= load_reg(2'd1);
          state   <= INIT1;
        end
        INIT1: begin
          count_q <= '0;
          if (n_q <= SIZE'(2)) begin
            last_addr <= (n_q == '0) ? 2'd0 : 2'(n_q - SIZE'(1));
            ctrl      <= park((n_q == '0) ? 2'd0 : 2'(n_q - SIZE'(1)));
            done_q    <= 1'b1;
            state     <= DONE;
          end else begin
            k     <= '0;
            ctrl  <= add_step(2'd0);
            state <= COMPUTE;
          end
        end
        COMPUTE: begin
          if (fault) begin
            ctrl   <= park(last_addr);
            err_q  <= 1'b1;
            done_q <= 1'b1;
            state  <= ERR;
          end else if (k == n_q - SIZE'(3)) begin
            last_addr <= 2'(k) + 2'd2;
            ctrl      <= park(2'(k) + 2'd2);
            done_q    <= 1'b1;
            state     <= DONE;
          end else begin
            k    <= k + SIZE'(1);
            ctrl <= add_step(2'(k) + 2'd1);
          end
        end
        DONE, ERR: begin
          busy_q <= 1'b0;
          ctrl   <= park(last_addr);
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          ctrl   <= park('0);
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.wrt_en     = ctrl.wrt_en;
  assign bus.load_data  = ctrl.load_data;
  assign bus.wrt_addr   = ctrl.wrt_addr;
  assign bus.rd_addr1   = ctrl.rd_addr1;
  assign bus.rd_addr2   = ctrl.rd_addr2;
  assign bus.alu_opcode = ctrl.alu_opcode;
  assign bus.count      = count_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_fibo_controller.sv
// Self-checking bench: behavioural register-file/ALU datapath plus a
// Fibonacci reference model; random and directed runs.
module tb_fibo_controller;
  import fibo_pkg::*;

  localparam int SIZE = 4;
`ifdef FIBO_OVF_DETECT_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic force_zero = 1'b0;
  int   n_checks = 0;
  int   n_errs = 0;

  always #5 clk = ~clk;

  fibo_if #(.SIZE(SIZE)) bus ();

  fibo_controller #(.SIZE(SIZE)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Behavioural datapath: 4-entry register file and PASS_A/ADD ALU.
  logic [3:0] rf [4];
  logic [3:0] alu_res;

  typedef struct packed {
    logic       is_add;
    reg_addr_t  addr;
    logic [3:0] val;
  } wr_t;
  wr_t wlog[$];

  always_comb begin
    alu_res = rf[bus.rd_addr1];
    if (bus.alu_opcode == OP_ADD) alu_res = 4'(rf[bus.rd_addr1] + rf[bus.rd_addr2]);
  end

  assign bus.data      = alu_res;
  assign bus.zero_flag = (alu_res == 4'd0) || force_zero;

  always @(posedge clk) begin
    if (bus.wrt_en) begin
      rf[bus.wrt_addr] <= bus.load_data ? bus.count : alu_res;
      wlog.push_back('{is_add: (bus.alu_opcode == OP_ADD), addr: bus.wrt_addr,
                       val: (bus.load_data ? bus.count : alu_res)});
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One run of term nv; force_at = cycle (after the start edge) whose
  // zero_flag is forced high, -1 for none.
  task automatic run_one(input logic [3:0] nv, input int force_at, input bit noise);
    logic [3:0] f [17];
    int   ne, err_step, last, exp_lat, cyc, n_wr;
    wr_t  e;
    string t;

    ne       = (nv == 4'd0) ? 1 : int'(nv);
    f[1]     = 4'd1;
    f[2]     = 4'd1;
    err_step = 0;
    for (int i = 3; i <= ne; i++) begin
      f[i] = 4'(f[i-1] + f[i-2]);
      if (err_step == 0 && (f[i] == 4'd0 || i == force_at || (OVF && f[i] < f[i-1])))
        err_step = i;
    end
    last    = (err_step != 0) ? err_step : ne;
    exp_lat = (err_step != 0) ? err_step + 1 : ((ne <= 2) ? 3 : ne + 1);
    n_wr    = (last <= 2) ? 2 : last;

    @(negedge clk);
    bus.start = 1'b1;
    bus.n     = nv;
    wlog.delete();
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      force_zero = (cyc == force_at);
      if (cyc == 1) begin
        t = $sformatf("n%0d_init0", nv);
        check(t, 32'({bus.busy, bus.err, bus.wrt_en, bus.load_data, bus.wrt_addr}),
              32'({1'b1, 1'b0, 1'b1, 1'b1, 2'd0}));
      end
      if (bus.done) break;
      bus.start = noise ? 1'($urandom) : 1'b0;
      bus.n     = noise ? 4'($urandom) : bus.n;
    end
    force_zero = 1'b0;
    bus.start  = 1'b0;

    check($sformatf("n%0d_latency", nv), 32'(cyc), 32'(exp_lat));
    check($sformatf("n%0d_err", nv), 32'(bus.err), 32'(err_step != 0));
    if (err_step == 0) begin
      check($sformatf("n%0d_data", nv), 32'(bus.data), 32'(f[ne]));
      check($sformatf("n%0d_park", nv),
            32'({bus.busy, bus.wrt_en, bus.alu_opcode, bus.rd_addr1}),
            32'({1'b1, 1'b0, OP_PASS_A, 2'(ne - 1)}));
    end

    check($sformatf("n%0d_nwrites", nv), 32'(wlog.size()), 32'(n_wr));
    for (int j = 0; j < n_wr && j < wlog.size(); j++) begin
      if (j < 2) e = '{is_add: 1'b0, addr: 2'(j), val: 4'd1};
      else       e = '{is_add: 1'b1, addr: 2'(j), val: f[j+1]};
      check($sformatf("n%0d_wr%0d", nv, j), 32'(wlog[j]), 32'(e));
    end

    @(negedge clk);
    check($sformatf("n%0d_idle", nv), 32'({bus.busy, bus.done, bus.err}),
          32'({1'b0, 1'b0, err_step != 0}));
    repeat (3) @(negedge clk);
    check($sformatf("n%0d_err_sticky", nv), 32'(bus.err), 32'(err_step != 0));
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 4; i++) rf[i] = 4'd0;
    bus.start = 1'b0;
    bus.n     = '0;

    repeat (2) @(negedge clk);
    check("reset_outputs",
          32'({bus.wrt_en, bus.load_data, bus.busy, bus.done, bus.err,
               bus.alu_opcode, bus.rd_addr1, bus.count}),
          32'({5'b0, OP_PASS_A, 2'd0, 4'd0}));
    rst_n = 1'b1;

    // Directed boundaries.
    run_one(4'd7, -1, 1'b0);
    run_one(4'd1, -1, 1'b0);
    run_one(4'd2, -1, 1'b0);
    run_one(4'd0, -1, 1'b0);
    run_one(4'd7, 5, 1'b0);
    run_one(4'd3, -1, 1'b0);
    run_one(4'd8, -1, 1'b0);
    run_one(4'd12, -1, 1'b0);

    // Reset in the middle of COMPUTE (k=2 for n=7).
    @(negedge clk);
    bus.start = 1'b1;
    bus.n     = 4'd7;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_outputs",
          32'({bus.wrt_en, bus.busy, bus.done, bus.err, bus.alu_opcode, bus.rd_addr1}),
          32'({4'b0, OP_PASS_A, 2'd0}));
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_stays_idle", 32'({bus.busy, bus.wrt_en}), 32'(0));
    run_one(4'd5, -1, 1'b0);

    // start held high: one IDLE cycle between done and the next INIT0.
    @(negedge clk);
    bus.start = 1'b1;
    bus.n     = 4'd3;
    cyc = 0;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bus.done) break;
    end
    check("b2b_lat1", 32'(cyc), 32'(4));
    @(negedge clk);
    check("b2b_idle", 32'({bus.busy, bus.done, bus.wrt_en}), 32'(0));
    @(negedge clk);
    check("b2b_init0", 32'({bus.busy, bus.wrt_en, bus.load_data, bus.wrt_addr}),
          32'({1'b1, 1'b1, 1'b1, 2'd0}));
    cyc = 1;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bus.done) break;
    end
    check("b2b_lat2", 32'(cyc), 32'(4));
    check("b2b_data", 32'(bus.data), 32'(2));
    bus.start = 1'b0;
    repeat (2) @(negedge clk);

    // Randomized runs with start/n noise while busy and occasional forced zero.
    for (int r = 0; r < 16; r++) begin
      run_one(4'($urandom_range(0, 15)),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 15)) : -1,
              1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
